// File: rtl/aoi_n1_pipe.sv
// Parametrised pipelined AOI (Y = ~(&A_group | B)) per channel with valid tag.
// Optional per-channel output toggle counters behind AOI_N1_PIPE_TOGGLE_CNT_EN.
module aoi_n1_pipe #(
    parameter int unsigned CH     = 4,
    parameter int unsigned N      = 3,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic                  VI,
    input  logic [CH*N-1:0]       A,
    input  logic [CH-1:0]         B,
`ifdef AOI_N1_PIPE_TOGGLE_CNT_EN
    input  logic                  CLR,
    output logic [CH*CNT_W-1:0]   TCNT,
`endif
    output logic [CH-1:0]         Y,
    output logic                  VO
);

    logic [CH-1:0] f_c;

    for (genvar c = 0; c < CH; c++) begin : g_core
        assign f_c[c] = ~(&A[c*N +: N] | B[c]);
    end

`ifdef AOI_N1_PIPE_TOGGLE_CNT_EN
    // Output value before and after the current edge, as seen by the counters.
    logic [CH-1:0] y_bef;
    logic [CH-1:0] y_aft;
    logic          vo_aft;
`endif

    if (STAGES == 0) begin : g_pass
        assign Y  = f_c;
        assign VO = VI;
`ifdef AOI_N1_PIPE_TOGGLE_CNT_EN
        logic [CH-1:0] y_prev_q;
        logic [CH-1:0] y_prev_d;

        always_comb begin
            y_prev_d = y_prev_q;
            if (RST) begin
                y_prev_d = '1;
            end else if (EN) begin
                y_prev_d = f_c;
            end
        end

        always_ff @(posedge CLK) begin
            y_prev_q <= y_prev_d;
        end

        assign y_bef  = y_prev_q;
        assign y_aft  = f_c;
        assign vo_aft = VI;
`endif
    end else begin : g_pipe
        logic [CH-1:0]     dat_q [STAGES];
        logic [CH-1:0]     dat_d [STAGES];
        logic [STAGES-1:0] vld_q;
        logic [STAGES-1:0] vld_d;

        always_comb begin
            dat_d = dat_q;
            vld_d = vld_q;
            if (RST) begin
                for (int unsigned k = 0; k < STAGES; k++) begin
                    dat_d[k] = '1;
                end
                vld_d = '0;
            end else if (EN) begin
                dat_d[0] = f_c;
                vld_d[0] = VI;
                for (int unsigned k = 1; k < STAGES; k++) begin
                    dat_d[k] = dat_q[k-1];
                    vld_d[k] = vld_q[k-1];
                end
            end
        end

        always_ff @(posedge CLK) begin
            dat_q <= dat_d;
            vld_q <= vld_d;
        end

        assign Y  = dat_q[STAGES-1];
        assign VO = vld_q[STAGES-1];
`ifdef AOI_N1_PIPE_TOGGLE_CNT_EN
        assign y_bef  = dat_q[STAGES-1];
        assign y_aft  = dat_d[STAGES-1];
        assign vo_aft = vld_d[STAGES-1];
`endif
    end

`ifdef AOI_N1_PIPE_TOGGLE_CNT_EN
    // Saturating toggle counters; clear wins over increment.
    logic [CH*CNT_W-1:0] tcnt_q;
    logic [CH*CNT_W-1:0] tcnt_d;

    always_comb begin
        tcnt_d = tcnt_q;
        for (int unsigned c = 0; c < CH; c++) begin
            if (RST || CLR) begin
                tcnt_d[c*CNT_W +: CNT_W] = '0;
            end else if (EN && vo_aft && (y_aft[c] != y_bef[c]) &&
                         (tcnt_q[c*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                tcnt_d[c*CNT_W +: CNT_W] = tcnt_q[c*CNT_W +: CNT_W] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        tcnt_q <= tcnt_d;
    end

    assign TCNT = tcnt_q;
`endif

endmodule
